// File: rtl/pmem_arbiter_rr_if.sv
// pmem_arbiter_rr_if: client request bus plus physical memory port.
// slave is the arbiter side; master is the client/memory side.
interface pmem_arbiter_rr_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [LINE_WIDTH-1:0]           req_rdata;
  logic                            pmem_resp;
  logic [LINE_WIDTH-1:0]           pmem_rdata;
  logic                            pmem_read;
  logic                            pmem_write;
  logic [ADDR_WIDTH-1:0]           pmem_address;
  logic [LINE_WIDTH-1:0]           pmem_wdata;
  logic                            timeout_err;

  modport slave (
    input  req_read, req_write,
    input  req_address, req_wdata,
    output req_resp, req_rdata,
    input  pmem_resp, pmem_rdata,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    output timeout_err
  );

  modport master (
    output req_read, req_write,
    output req_address, req_wdata,
    input  req_resp, req_rdata,
    output pmem_resp, pmem_rdata,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    input  timeout_err
  );
endinterface

// File: rtl/pmem_arbiter_rr.sv
// pmem_arbiter_rr: round-robin arbiter of N line clients onto one pmem port.
// Define PMEM_ARB_TIMEOUT_EN for a BUSY watchdog with sticky timeout_err.
module pmem_arbiter_rr #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_arbiter_rr_if.slave bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pmem_arbiter_rr: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  resp_q, resp_d;

  logic [NUM_PORTS-1:0]  reqs;
  logic                  sel_vld;
  logic [PW-1:0]         sel_idx;
  logic                  tmo;

  assign reqs = bus.req_read | bus.req_write;

  // Pick the first requester at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    logic [PW:0] sum;
    sel_vld = 1'b0;
    sel_idx = '0;
    sum     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_PORTS))
        sum = sum - (PW+1)'(NUM_PORTS);
      if (reqs[sum[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = sum[PW-1:0];
      end
    end
  end

`ifdef PMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Count BUSY cycles; zero outside BUSY so each grant starts fresh.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY)
      cnt_d = cnt_q + 1'b1;
  end

  assign tmo = (state_q == BUSY) &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Error flag latches on a timeout that no pmem_resp rescued.
  always_comb begin
    err_d = err_q;
    if (tmo && !bus.pmem_resp)
      err_d = 1'b1;
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign tmo             = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state and registered outputs of the IDLE/BUSY/RESP controller.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    resp_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_d = sel_idx;
          addr_d  = bus.req_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.req_wdata[sel_idx*LINE_WIDTH +: LINE_WIDTH];
          wr_d    = bus.req_write[sel_idx];
          rd_d    = ~bus.req_write[sel_idx];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.pmem_resp || tmo) begin
          if (bus.pmem_resp && rd_q)
            rdata_d = bus.pmem_rdata;
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          resp_d[grant_q] = 1'b1;
          if (grant_q == PW'(NUM_PORTS - 1))
            rr_ptr_d = '0;
          else
            rr_ptr_d = grant_q + 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
    end
  end

  assign bus.req_resp     = resp_q;
  assign bus.req_rdata    = rdata_q;
  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// tb_pmem_arbiter_rr: scoreboard bench for the round-robin pmem arbiter.
// Four ports, TIMEOUT_CYCLES=16; all driving and sampling on negedge.
module tb_pmem_arbiter_rr;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 16;

  typedef struct packed {
    logic [NP-1:0] port;
    logic [LW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pmem_arbiter_rr_if #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW)
  ) bus ();

  pmem_arbiter_rr #(
    .NUM_PORTS     (NP),
    .ADDR_WIDTH    (AW),
    .LINE_WIDTH    (LW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  exp_t          sb[$];
  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  int            presp_cyc = -1;
  int            mem_lat = 5;
  int            busy_cnt = 0;
  int            resp_cnt = 0;
  logic [NP-1:0] last_resp = '0;
  logic [LW-1:0] model_rdata = '0;

  function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h0000_1000)
      return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic drive_rd(input int p, input logic [AW-1:0] a);
    bus.req_address[p*AW +: AW] = a;
    bus.req_read[p] = 1'b1;
  endtask

  task automatic expect_resp(input int p, input logic [LW-1:0] d);
    logic [NP-1:0] one;
    one = 1;
    sb.push_back(exp_t'{port: one << p, data: d});
  endtask

  task automatic req_rd(input int p, input logic [AW-1:0] a);
    drive_rd(p, a);
    model_rdata = mem_data(a);
    expect_resp(p, model_rdata);
  endtask

  task automatic req_wr(input int p, input logic [AW-1:0] a,
                        input logic [LW-1:0] d);
    bus.req_address[p*AW +: AW] = a;
    bus.req_wdata[p*LW +: LW] = d;
    bus.req_write[p] = 1'b1;
    expect_resp(p, model_rdata);
  endtask

  // One cycle: memory model, protocol monitor, scoreboard, client drop.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.pmem_resp) begin
      bus.pmem_resp = 1'b0;
      busy_cnt = 0;
    end else if (bus.pmem_read || bus.pmem_write) begin
      busy_cnt++;
      if (mem_lat != 0 && busy_cnt >= mem_lat) begin
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mem_data(bus.pmem_address);
        presp_cyc = cyc;
      end
    end
    if (bus.pmem_read || bus.pmem_write) begin
      checks++;
      if (bus.pmem_read && bus.pmem_write) begin
        fails++;
        $display("FAIL rd_wr_excl: both strobes high at cycle %0d", cyc);
      end
    end
    if (bus.req_resp != '0) begin
      checks++;
      if ($countones(bus.req_resp) != 1) begin
        fails++;
        $display("FAIL resp_onehot: got %b want one-hot", bus.req_resp);
      end
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got %b want none", bus.req_resp);
      end else begin
        e = sb.pop_front();
        if (bus.req_resp !== e.port || bus.req_rdata !== e.data) begin
          fails++;
          $display("FAIL resp: got %b/%h want %b/%h",
                   bus.req_resp, bus.req_rdata, e.port, e.data);
        end
      end
      if (presp_cyc >= 0) begin
        checks++;
        if (cyc - presp_cyc != 1) begin
          fails++;
          $display("FAIL resp_latency: got %0d want 1", cyc - presp_cyc);
        end
      end
      presp_cyc = -1;
      bus.req_read = bus.req_read & ~bus.req_resp;
      bus.req_write = bus.req_write & ~bus.req_resp;
      last_resp = bus.req_resp;
      resp_cnt++;
    end
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.pmem_read || bus.pmem_write)
           && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      fails++;
      $display("FAIL wait_done: got %0d pending want 0", sb.size());
    end
    step();
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_read = '0;
    bus.req_write = '0;
    bus.pmem_resp = 1'b0;
    sb.delete();
    model_rdata = '0;
    busy_cnt = 0;
    presp_cyc = -1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.req_address = '0;
    bus.req_wdata = '0;
    bus.pmem_rdata = '0;
    do_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.req_resp !== '0 || bus.req_rdata !== '0) begin
      fails++;
      $display("FAIL reset_resp: got %b/%h want 0", bus.req_resp, bus.req_rdata);
    end
    checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: got %b%b want 00",
               bus.pmem_read, bus.pmem_write);
    end
    checks++;
    if (bus.pmem_address !== '0 || bus.pmem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_bus: got %h want 0", bus.pmem_address);
    end
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: got %b want 0", bus.timeout_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    int r0;
    r0 = resp_cnt;
    mem_lat = 5;
    req_rd(0, 32'h0000_1000);
    step();
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin
      fails++;
      $display("FAIL rd_strobe: got %b%b want 10",
               bus.pmem_read, bus.pmem_write);
    end
    checks++;
    if (bus.pmem_address !== 32'h0000_1000) begin
      fails++;
      $display("FAIL rd_addr: got %h want 00001000", bus.pmem_address);
    end
    wait_done(40);
    checks++;
    if (resp_cnt - r0 != 1 || last_resp !== 4'b0001) begin
      fails++;
      $display("FAIL rd_resp: got %0d/%b want 1/0001",
               resp_cnt - r0, last_resp);
    end
  endtask

  task automatic test_two_ports();
    int r0;
    do_reset();
    r0 = resp_cnt;
    mem_lat = 4;
    req_rd(0, 32'h0000_3000);
    req_rd(1, 32'h0000_3040);
    wait_done(60);
    checks++;
    if (resp_cnt - r0 != 2 || last_resp !== 4'b0010) begin
      fails++;
      $display("FAIL two_ports: got %0d/%b want 2/0010",
               resp_cnt - r0, last_resp);
    end
  endtask

  task automatic test_write();
    int r0;
    int n;
    int wcnt;
    logic [LW-1:0] wd;
    wd = {8{32'h1234_5678}};
    r0 = resp_cnt;
    n = 0;
    wcnt = 0;
    mem_lat = 10;
    req_wr(1, 32'h0000_2000, wd);
    while (resp_cnt == r0 && n < 40) begin
      step();
      n++;
      if (bus.pmem_write) begin
        wcnt++;
        checks++;
        if (bus.pmem_wdata !== wd || bus.pmem_read !== 1'b0 ||
            bus.pmem_address !== 32'h0000_2000) begin
          fails++;
          $display("FAIL wr_hold: got %h/%b want %h/0",
                   bus.pmem_address, bus.pmem_read, 32'h0000_2000);
        end
      end
    end
    checks++;
    if (wcnt != 10 || last_resp !== 4'b0010) begin
      fails++;
      $display("FAIL wr_busy: got %0d/%b want 10/0010", wcnt, last_resp);
    end
    step();
    step();
    mem_lat = 5;
  endtask

  task automatic test_four_ports();
    int issued;
    int pend;
    int r;
    int n;
    do_reset();
    mem_lat = 2;
    for (int p = 0; p < NP; p++)
      req_rd(p, 32'h0000_6000 + 32'(p) * 32'h40);
    issued = NP;
    pend = -1;
    n = 0;
    while ((sb.size() != 0 || issued < 2 * NP) && n < 200) begin
      r = resp_cnt;
      step();
      n++;
      if (pend >= 0) begin
        req_rd(pend, 32'h0000_7000 + 32'(pend) * 32'h40);
        issued++;
        pend = -1;
      end
      if (resp_cnt != r && issued < 2 * NP)
        pend = $clog2(last_resp);
    end
    checks++;
    if (n >= 200 || issued != 2 * NP) begin
      fails++;
      $display("FAIL four_ports: got %0d issued want %0d", issued, 2 * NP);
    end
    wait_done(40);
  endtask

  task automatic test_reset_busy();
    int r0;
    mem_lat = 0;
    drive_rd(2, 32'h0000_4000);
    step();
    step();
    checks++;
    if (bus.pmem_read !== 1'b1) begin
      fails++;
      $display("FAIL busy_pre: got %b want 1", bus.pmem_read);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: got %b want 0", bus.pmem_read);
    end
    bus.req_read = '0;
    bus.req_write = '0;
    sb.delete();
    model_rdata = '0;
    busy_cnt = 0;
    step();
    rst_n = 1'b1;
    r0 = resp_cnt;
    repeat (5) step();
    checks++;
    if (resp_cnt != r0 || bus.pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got %0d resp want 0", resp_cnt - r0);
    end
    bus.pmem_resp = 1'b1;
    repeat (3) step();
    checks++;
    if (resp_cnt != r0) begin
      fails++;
      $display("FAIL idle_presp: got %0d resp want 0", resp_cnt - r0);
    end
    mem_lat = 3;
    req_rd(0, 32'h0000_4100);
    req_rd(1, 32'h0000_4200);
    bus.req_address[1*AW +: AW] = 32'h0000_4200;
    wait_done(60);
    checks++;
    if (resp_cnt - r0 != 2 || last_resp !== 4'b0010) begin
      fails++;
      $display("FAIL reset_rr: got %0d/%b want 2/0010",
               resp_cnt - r0, last_resp);
    end
  endtask

  task automatic test_timeout();
    int r0;
    int n;
    int bcnt;
    r0 = resp_cnt;
    mem_lat = 0;
    n = 0;
    bcnt = 0;
    drive_rd(3, 32'h0000_5000);
`ifdef PMEM_ARB_TIMEOUT_EN
    expect_resp(3, model_rdata);
    while (resp_cnt == r0 && n < 100) begin
      step();
      n++;
      if (bus.pmem_read)
        bcnt++;
    end
    checks++;
    if (bcnt != TO || bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout: got %0d/%b want %0d/1",
               bcnt, bus.timeout_err, TO);
    end
    repeat (3) step();
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL timeout_sticky: got %b want 1", bus.timeout_err);
    end
`else
    repeat (40) step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.pmem_read !== 1'b1 ||
        resp_cnt != r0) begin
      fails++;
      $display("FAIL no_timeout: got %b/%b want 0/1",
               bus.timeout_err, bus.pmem_read);
    end
    model_rdata = mem_data(32'h0000_5000);
    expect_resp(3, model_rdata);
    mem_lat = busy_cnt + 1;
    wait_done(20);
    checks++;
    if (last_resp !== 4'b1000 || bus.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL late_resp: got %b want 1000", last_resp);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_read = '0;
    bus.req_write = '0;
    bus.pmem_resp = 1'b0;
    test_reset();
    test_single_read();
    test_two_ports();
    test_write();
    test_four_ports();
    test_reset_busy();
    test_timeout();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
